// File: rtl/a2d_arb_pkg.sv
// a2d_pkg: shared types and widths for the A2D round-robin arbiter.
//   arb_state_t : arbiter FSM states
//   RES_W       : A2D result width
//   CHNL_W      : A2D channel select width
package a2d_pkg;
  localparam int RES_W  = 12;
  localparam int CHNL_W = 3;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/a2d_arb_if.sv
// a2d_arb_if: handshake between the arbiter and the A2D_intf front end.
//   strt_cnv  : one-cycle conversion start   (arbiter -> A2D)
//   chnnl     : channel to convert           (arbiter -> A2D)
//   cnv_cmplt : one-cycle completion pulse   (A2D -> arbiter)
//   res       : conversion result            (A2D -> arbiter)
// master = arbiter side, slave = A2D_intf side.
interface a2d_arb_if;
  import a2d_pkg::*;

  logic              strt_cnv;
  logic [CHNL_W-1:0] chnnl;
  logic              cnv_cmplt;
  logic [RES_W-1:0]  res;

  modport master (output strt_cnv, chnnl, input  cnv_cmplt, res);
  modport slave  (input  strt_cnv, chnnl, output cnv_cmplt, res);
endinterface

// File: rtl/a2d_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : request vector
//   ptr    : highest-priority index (must be < NUM_REQ)
//   any    : at least one request present
//   winner : first set bit scanning ptr, ptr+1, ... wrapping at NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               any,
  output logic [PTR_W-1:0]   winner
);
  logic [PTR_W-1:0] w_idx;

  // Scan from the farthest offset down to ptr so the last hit,
  // i.e. the closest to ptr, is the one that sticks.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    w_idx  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (req[w_idx]) begin
        any    = 1'b1;
        winner = w_idx;
      end
    end
  end
endmodule

// File: rtl/a2d_arb.sv
// a2d_arb: round-robin arbiter sharing one A2D_intf among NUM_REQ requesters.
//   clk, rst   : clock, synchronous active-high reset
//   req        : level request per requester, held until its done
//   req_chnnl  : 3-bit channel per requester, slice i = [3i+2:3i]
//   gnt        : one-hot grant, held for the whole transaction
//   done       : one-cycle pulse to the granted requester, res_out valid
//   err        : pulses with done when the conversion timed out
//   res_out    : conversion result (0 on timeout)
//   busy       : FSM not in IDLE
//   a2d        : strt_cnv/chnnl out, cnv_cmplt/res in
// All outputs are registers or decodes of the registered state, so there is
// no combinational path from req to gnt or strt_cnv.
module a2d_arb
  import a2d_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [CHNL_W*NUM_REQ-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [RES_W-1:0]          res_out,
  output logic                      busy,
  a2d_arb_if.master                 a2d
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_win;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_err;
  logic [RES_W-1:0]  r_res_out;
  logic              r_strt;
  logic [CHNL_W-1:0] r_chnnl;

  logic              w_any;
  logic [PTR_W-1:0]  w_winner;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .any    (w_any),
    .winner (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_res_out <= '0;
      r_strt    <= 1'b0;
      r_chnnl   <= '0;
    end else begin
      // pulse outputs default low
      r_done <= '0;
      r_err  <= '0;
      r_strt <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_gnt   <= NUM_REQ'(1) << w_winner;
          r_win   <= w_winner;
          r_chnnl <= req_chnnl[int'(w_winner)*CHNL_W +: CHNL_W];
          r_strt  <= 1'b1;  // high for the single START cycle
          r_state <= START;
        end
        START: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (a2d.cnv_cmplt) begin
            r_res_out <= a2d.res;
            r_done    <= r_gnt;
            r_state   <= DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
            // conversion never finished; hand back a zero result with err
            r_res_out <= '0;
            r_done    <= r_gnt;
            r_err     <= r_gnt;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_gnt     <= '0;
          r_res_out <= '0;
          r_ptr     <= (r_win == PTR_W'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign done         = r_done;
  assign err          = r_err;
  assign res_out      = r_res_out;
  assign busy         = (r_state != IDLE);
  assign a2d.strt_cnv = r_strt;
  assign a2d.chnnl    = r_chnnl;
endmodule

// File: tb/tb_a2d_arb.sv
// tb_a2d_arb: directed bench for a2d_arb with a scoreboard of expected
// done/result pairs and a behavioural A2D model. A second instance with a
// short TIMEOUT and a silent A2D exercises the watchdog.
module tb_a2d_arb;
  localparam int NR   = 4;
  localparam int TO_T = 16;

  typedef struct {
    int          id;
    logic [11:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] req_chnnl = '0;
  logic [3:0]  gnt, done, err;
  logic [11:0] res_out;
  logic        busy;

  logic [3:0]  to_req = '0;
  logic [11:0] to_chnl = 12'h00A;
  logic [3:0]  to_gnt, to_done, to_err;
  logic [11:0] to_res_out;
  logic        to_busy;

  int  cyc = 0, n_chk = 0, n_err = 0;
  int  strt_since = 0, last_cmplt = -10;
  int  model_lat = 3, spur_req = 0, spur_done = 0;
  bit  mute = 1'b0;
  exp_t        sb[$];
  logic [11:0] model_q[$];

  a2d_arb_if a2d_if();
  a2d_arb_if to_if();

  a2d_arb #(.NUM_REQ(NR), .TIMEOUT(4096)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_chnnl(req_chnnl),
    .gnt(gnt), .done(done), .err(err), .res_out(res_out), .busy(busy),
    .a2d(a2d_if)
  );

  a2d_arb #(.NUM_REQ(NR), .TIMEOUT(TO_T)) u_to (
    .clk(clk), .rst(rst), .req(to_req), .req_chnnl(to_chnl),
    .gnt(to_gnt), .done(to_done), .err(to_err), .res_out(to_res_out), .busy(to_busy),
    .a2d(to_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_xact(input int id, input logic [11:0] r);
    exp_t e;
    e.id = id;
    e.res = r;
    sb.push_back(e);
    model_q.push_back(r);
  endtask

  task automatic wait_strt();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a2d_if.strt_cnv) begin seen = 1'b1; break; end
    end
    chk("strt_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int id);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done[id]) begin seen = 1'b1; break; end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic xact(input int id);
    wait_strt();
    chk("gnt_order", 32'(gnt), 32'(4'b0001 << id));
    wait_done(id);
  endtask

  // A2D model: answers each strt_cnv model_lat cycles later with the next
  // queued result; also issues a stray cnv_cmplt on demand.
  initial begin
    logic [11:0] rv;
    a2d_if.cnv_cmplt = 1'b0;
    a2d_if.res       = '0;
    to_if.cnv_cmplt  = 1'b0;
    to_if.res        = '0;
    forever begin
      @(negedge clk);
      if (a2d_if.strt_cnv && !mute) begin
        rv = (model_q.size() > 0) ? model_q.pop_front() : 12'h000;
        repeat (model_lat-1) @(posedge clk);
        #1 a2d_if.cnv_cmplt = 1'b1; a2d_if.res = rv;
        @(posedge clk);
        #1 a2d_if.cnv_cmplt = 1'b0; a2d_if.res = '0;
      end else if (spur_req != spur_done) begin
        spur_done = spur_req;
        @(posedge clk);
        #1 a2d_if.cnv_cmplt = 1'b1; a2d_if.res = 12'hFFF;
        @(posedge clk);
        #1 a2d_if.cnv_cmplt = 1'b0; a2d_if.res = '0;
      end
    end
  end

  // Monitor: grant shape, one start per grant, and done/result vs scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) strt_since = 0;
      if (a2d_if.cnv_cmplt) last_cmplt = cyc;
      if (a2d_if.strt_cnv) strt_since++;
      if (gnt != '0) chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      if (done != '0) begin
        if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          e = sb.pop_front();
          chk("done_id", 32'(done), 32'(4'b0001 << e.id));
          chk("res_out", 32'(res_out), 32'(e.res));
          chk("err_clear", 32'(err), 32'd0);
          chk("done_latency", 32'(cyc), 32'(last_cmplt + 1));
          chk("strt_per_gnt", 32'(strt_since), 32'd1);
          strt_since = 0;
        end
      end
    end
  end

  initial begin
    int ts, td;
    bit seen;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_res_out", 32'(res_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strt", 32'(a2d_if.strt_cnv), 32'd0);
    chk("rst_chnnl", 32'(a2d_if.chnnl), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // contention: all four held, order 0,1,2,3,0
    #1 model_lat = 3;
    req_chnnl = {3'd3, 3'd2, 3'd1, 3'd0};
    expect_xact(0, 12'h101); expect_xact(1, 12'h202); expect_xact(2, 12'h303);
    expect_xact(3, 12'h404); expect_xact(0, 12'h505);
    req = 4'b1111;
    xact(0); xact(1); xact(2); xact(3); xact(0);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("cont_idle", 32'(busy), 32'd0);

    // single requester 2, channel 5, result after 20 cycles
    @(posedge clk); #1 model_lat = 20;
    req_chnnl = 12'd5 << 6;
    expect_xact(2, 12'hA5C);
    req = 4'b0100;
    @(negedge clk);
    chk("no_comb_gnt", 32'(gnt), 32'd0);
    chk("no_comb_strt", 32'(a2d_if.strt_cnv), 32'd0);
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_chnnl", 32'(a2d_if.chnnl), 32'd5);
    chk("single_strt", 32'(a2d_if.strt_cnv), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    wait_done(2);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_gnt_clr", 32'(gnt), 32'd0);

    // requester 1 alone moves ptr to 2; then 0 and 1 together: 0 first
    @(posedge clk); #1 model_lat = 4;
    expect_xact(1, 12'h011);
    req = 4'b0010;
    xact(1);
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1
    expect_xact(0, 12'h0AA); expect_xact(1, 12'h0BB);
    req = 4'b0011;
    xact(0);
    @(posedge clk); #1 req[0] = 1'b0;
    xact(1);
    @(posedge clk); #1 req = '0;

    // reset mid-WAIT: no done, then requester 3 from a fresh start
    @(posedge clk); #1 mute = 1'b1;
    req = 4'b0100;
    wait_strt();
    chk("rstw_gnt", 32'(gnt), 32'h4);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req = '0; mute = 1'b0;
    @(negedge clk);
    chk("rstw_gnt_clr", 32'(gnt), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 model_lat = 5;
    expect_xact(3, 12'h7E1);
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_gnt3", 32'(gnt), 32'h8);
    chk("rstw_strt3", 32'(a2d_if.strt_cnv), 32'd1);
    wait_done(3);
    @(posedge clk); #1 req = '0;

    // stray cnv_cmplt in IDLE, then req_chnnl change during WAIT
    @(posedge clk); #1 spur_req++;
    repeat (5) @(negedge clk);
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1 model_lat = 8;
    req_chnnl = 12'd6;
    expect_xact(0, 12'h3C9);
    req = 4'b0001;
    wait_strt();
    chk("hold_gnt", 32'(gnt), 32'h1);
    chk("hold_chnnl0", 32'(a2d_if.chnnl), 32'd6);
    @(posedge clk); #1 req_chnnl = 12'd1;
    repeat (3) @(negedge clk);
    chk("hold_chnnl", 32'(a2d_if.chnnl), 32'd6);
    wait_done(0);
    @(posedge clk); #1 req = '0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // watchdog on the short-TIMEOUT instance: silent A2D
    @(posedge clk); #1 to_req = 4'b0001;
    seen = 1'b0; ts = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (to_if.strt_cnv) begin seen = 1'b1; ts = cyc; break; end
    end
    chk("to_strt_seen", 32'(seen), 32'd1);
    seen = 1'b0; td = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (to_done != '0) begin seen = 1'b1; td = cyc; break; end
    end
    chk("to_done_seen", 32'(seen), 32'd1);
    chk("to_done", 32'(to_done), 32'h1);
    chk("to_err", 32'(to_err), 32'h1);
    chk("to_res_out", 32'(to_res_out), 32'd0);
    // TIMEOUT cycles spent in WAIT between START and DONE
    chk("to_wait_cycles", 32'(td - ts - 1), 32'(TO_T));
    @(posedge clk); #1 to_req = '0;
    @(negedge clk);
    chk("to_idle", 32'(to_busy), 32'd0);
    chk("to_gnt_clr", 32'(to_gnt), 32'd0);
    chk("to_err_clr", 32'(to_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
